fft64_col_reorder: RTL and testbench

- Output-side transpose/reorder buffer for the 64-point radix-8 FFT datapath.
- Accepts packed 8-lane complex rows (the same 80-bit re/im format the twiddle multiplier stage produces) and emits them column by column in natural frequency order.
- Ping-pong storage of two 64-sample frames, so the FFT core can stream frames back-to-back while the downstream reader drains.
- Sits after the final butterfly stage and before the output interface.

---
 rtl/fft64_col_reorder_pkg.sv | 21 ++
 rtl/fft64_col_reorder_if.sv | 27 ++
 rtl/fft64_tbuf_bank.sv | 43 ++++
 rtl/fft64_col_reorder.sv | 93 +++++++++
 tb/tb_fft64_col_reorder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft64_col_reorder_pkg.sv
// Shared constants, the complex sample type and the lane slice helper for the
// 64-point FFT output transpose buffer.
package fft64_col_reorder_pkg;

    localparam int DW         = 10;
    localparam int LANES      = 8;
    localparam int FRAME_ROWS = 8;
    localparam int IDXW       = 3;
    localparam int VW         = DW * LANES;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Lane j of a packed vector occupies bits [DW*j+DW-1 : DW*j].
    function automatic logic [DW-1:0] lane_get(input logic [VW-1:0] vec, input int j);
        return vec[DW*j +: DW];
    endfunction

endpackage

// File: rtl/fft64_col_reorder_if.sv
// Row-in / column-out stream bundle of the transpose buffer; slave is the
// buffer's own view, master is the side that feeds rows and drains columns.
interface fft64_col_reorder_if;
    import fft64_col_reorder_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] dinre;
    logic [VW-1:0] dinim;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] doutre;
    logic [VW-1:0] doutim;
    logic [2:0]    out_col;
    logic          out_last;

    modport slave (
        input  in_valid, dinre, dinim, out_ready,
        output in_ready, out_valid, doutre, doutim, out_col, out_last
    );

    modport master (
        output in_valid, dinre, dinim, out_ready,
        input  in_ready, out_valid, doutre, doutim, out_col, out_last
    );

endinterface

// File: rtl/fft64_tbuf_bank.sv
// One 8x8 complex storage bank: a whole row is written per cycle, and a whole
// column is read combinationally so data is visible the cycle after the write.
module fft64_tbuf_bank
    import fft64_col_reorder_pkg::*;
(
    input  logic            clk,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_row,
    input  logic [VW-1:0]   wr_re,
    input  logic [VW-1:0]   wr_im,
    input  logic [IDXW-1:0] rd_col,
    output logic [VW-1:0]   rd_re,
    output logic [VW-1:0]   rd_im
);

    cplx_t cells [FRAME_ROWS][LANES];
    cplx_t wr_word [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_wr_lane
            assign wr_word[gi].re = lane_get(wr_re, gi);
            assign wr_word[gi].im = lane_get(wr_im, gi);
        end
    endgenerate

    // Contents are never reset; the full flags in the controller qualify them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                cells[wr_row][j] <= wr_word[j];
            end
        end
    end

    // Output lane r carries stored row r at the selected column.
    generate
        for (genvar gi = 0; gi < FRAME_ROWS; gi++) begin : g_rd_row
            assign rd_re[DW*gi +: DW] = cells[gi][rd_col].re;
            assign rd_im[DW*gi +: DW] = cells[gi][rd_col].im;
        end
    endgenerate

endmodule

// File: rtl/fft64_col_reorder.sv
// Ping-pong transpose buffer: rows of 8 complex samples in, columns out in
// natural frequency order, two frames deep so writer and reader overlap.
module fft64_col_reorder
    import fft64_col_reorder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fft64_col_reorder_if.slave   bus
);

    logic            wr_bank_q, wr_bank_d;
    logic [IDXW-1:0] wr_row_q,  wr_row_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IDXW-1:0] rd_col_q,  rd_col_d;
    logic [1:0]      full_q,    full_d;

    logic in_ready_c;
    logic out_valid_c;
    logic accept;
    logic consume;

    logic [VW-1:0] bank_re [2];
    logic [VW-1:0] bank_im [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
            full_q    <= full_d;
        end
    end

    always_comb begin
        in_ready_c  = ~full_q[wr_bank_q];
        out_valid_c = full_q[rd_bank_q];
        accept      = bus.in_valid & in_ready_c;
        consume     = out_valid_c & bus.out_ready;

        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        full_d    = full_q;

        // Clear and set can only ever hit different banks: a full bank blocks writes.
        if (consume) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'(LANES - 1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end

        if (accept) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'(FRAME_ROWS - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            fft64_tbuf_bank u_bank (
                .clk    (clk),
                .wr_en  (accept & (wr_bank_q == 1'(gi))),
                .wr_row (wr_row_q),
                .wr_re  (bus.dinre),
                .wr_im  (bus.dinim),
                .rd_col (rd_col_q),
                .rd_re  (bank_re[gi]),
                .rd_im  (bank_im[gi])
            );
        end
    endgenerate

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.doutre    = out_valid_c ? bank_re[rd_bank_q] : '0;
    assign bus.doutim    = out_valid_c ? bank_im[rd_bank_q] : '0;
    assign bus.out_col   = rd_col_q;
    assign bus.out_last  = out_valid_c & (rd_col_q == 3'(LANES - 1));

endmodule

// File: tb/tb_fft64_col_reorder.sv
// Directed bench for the FFT column reorder buffer with a transpose scoreboard.
module tb_fft64_col_reorder;
    import fft64_col_reorder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft64_col_reorder_if bus();

    fft64_col_reorder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [79:0] re;
        logic [79:0] im;
        logic [2:0]  col;
        logic        last;
    } col_t;

    col_t        exp_q[$];
    logic [79:0] mre [8];
    logic [79:0] mim [8];
    int          mrow = 0;
    int          total = 0;
    int          bad = 0;
    int          consumed = 0;
    logic [9:0]  ext [3];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mk(input int base, input int r, output logic [79:0] re, output logic [79:0] im);
        int v;
        for (int j = 0; j < 8; j++) begin
            v = base + 8*r + j;
            re[10*j +: 10] = 10'(v);
            im[10*j +: 10] = 10'(-v);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, account for the handshakes
    // that the following rising edge will perform.
    task automatic cyc(input logic iv, input logic [79:0] re, input logic [79:0] im, input logic ordy);
        col_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.dinre     = re;
        bus.dinim     = im;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid !== 1'b1) begin
            chk("idle_re", bus.doutre, 80'd0);
            chk("idle_im", bus.doutim, 80'd0);
        end else if (ordy) begin
            chk("col_avail", 80'(exp_q.size() > 0), 80'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_re", bus.doutre, e.re);
                chk("sb_im", bus.doutim, e.im);
                chk("sb_col", 80'(bus.out_col), 80'(e.col));
                chk("sb_last", 80'(bus.out_last), 80'(e.last));
            end
            consumed++;
        end
        if (iv && bus.in_ready === 1'b1) begin
            mre[mrow] = re;
            mim[mrow] = im;
            mrow++;
            if (mrow == 8) begin
                for (int c = 0; c < 8; c++) begin
                    for (int r = 0; r < 8; r++) begin
                        e.re[10*r +: 10] = mre[r][10*c +: 10];
                        e.im[10*r +: 10] = mim[r][10*c +: 10];
                    end
                    e.col  = 3'(c);
                    e.last = (c == 7);
                    exp_q.push_back(e);
                end
                mrow = 0;
            end
        end
    endtask

    initial begin
        logic [79:0] re, im;
        logic [95:0] rnd_re, rnd_im;
        int snap;

        ext[0] = 10'h1FF; ext[1] = 10'h200; ext[2] = 10'h000;
        bus.in_valid = 1'b0; bus.dinre = '0; bus.dinim = '0; bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 80'(bus.in_ready), 80'd1);
        chk("rst_out_valid", 80'(bus.out_valid), 80'd0);
        chk("rst_doutre", bus.doutre, 80'd0);
        chk("rst_doutim", bus.doutim, 80'd0);
        chk("rst_out_col", 80'(bus.out_col), 80'd0);
        chk("rst_out_last", 80'(bus.out_last), 80'd0);

        // Single frame: re = 8r+j, im = -(8r+j)
        for (int r = 0; r < 8; r++) begin
            mk(0, r, re, im);
            cyc(1'b1, re, im, 1'b1);
        end
        chk("sf_not_yet_valid", 80'(bus.out_valid), 80'd0);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, '0, '0, 1'b1);
            if (c == 0) begin
                chk("sf_valid_1cyc", 80'(bus.out_valid), 80'd1);
                chk("sf_c0_col", 80'(bus.out_col), 80'd0);
                chk("sf_c0_last", 80'(bus.out_last), 80'd0);
                chk("sf_c0_re_l0", 80'(bus.doutre[9:0]), 80'd0);
                chk("sf_c0_re_l7", 80'(bus.doutre[79:70]), 80'd56);
                chk("sf_c0_im_l1", 80'(bus.doutim[19:10]), 80'h3F8);
                chk("sf_c0_im_l7", 80'(bus.doutim[79:70]), 80'h3C8);
            end
            if (c == 7) begin
                chk("sf_c7_col", 80'(bus.out_col), 80'd7);
                chk("sf_c7_last", 80'(bus.out_last), 80'd1);
                chk("sf_c7_re_l3", 80'(bus.doutre[39:30]), 80'd31);
            end
        end
        cyc(1'b0, '0, '0, 1'b1);
        chk("sf_drained", 80'(bus.out_valid), 80'd0);
        chk("sf_in_ready", 80'(bus.in_ready), 80'd1);

        // Back-to-back: 4 frames, no bubbles
        snap = consumed;
        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < 8; r++) begin
                mk(64*(f+1), r, re, im);
                cyc(1'b1, re, im, 1'b1);
                chk("b2b_in_ready", 80'(bus.in_ready), 80'd1);
                if (f > 0) chk("b2b_out_valid", 80'(bus.out_valid), 80'd1);
            end
        end
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, '0, '0, 1'b1);
            chk("b2b_drain_valid", 80'(bus.out_valid), 80'd1);
        end
        chk("b2b_col_count", 80'(consumed - snap), 80'd32);
        chk("b2b_q_empty", 80'(exp_q.size()), 80'd0);

        // Backpressure: both banks fill
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 8; r++) begin
                mk(512 + 64*f, r, re, im);
                cyc(1'b1, re, im, 1'b0);
                chk("bp_fill_ready", 80'(bus.in_ready), 80'd1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            mk(640, 0, re, im);
            cyc(1'b1, re, im, 1'b0);
            chk("bp_in_ready_low", 80'(bus.in_ready), 80'd0);
            chk("bp_hold_col", 80'(bus.out_col), 80'd0);
            chk("bp_hold_re_l0", 80'(bus.doutre[9:0]), 80'h200);
            chk("bp_hold_re_l1", 80'(bus.doutre[19:10]), 80'h208);
        end
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, '0, '0, 1'b1);
            chk("bp_drain_ready_low", 80'(bus.in_ready), 80'd0);
        end
        cyc(1'b0, '0, '0, 1'b1);
        chk("bp_in_ready_back", 80'(bus.in_ready), 80'd1);
        chk("bp_frame1_col0", 80'(bus.out_col), 80'd0);
        for (int c = 0; c < 7; c++) cyc(1'b0, '0, '0, 1'b1);
        chk("bp_q_empty", 80'(exp_q.size()), 80'd0);

        // Random stall against the scoreboard
        for (int k = 0; k < 300; k++) begin
            rnd_re = {$urandom, $urandom, $urandom};
            rnd_im = {$urandom, $urandom, $urandom};
            cyc(1'($urandom_range(0, 1)), rnd_re[79:0], rnd_im[79:0], 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 16 && mrow != 0; k++) begin
            rnd_re = {$urandom, $urandom, $urandom};
            rnd_im = {$urandom, $urandom, $urandom};
            cyc(1'b1, rnd_re[79:0], rnd_im[79:0], 1'b1);
        end
        for (int k = 0; k < 20; k++) cyc(1'b0, '0, '0, 1'b1);
        chk("rnd_q_empty", 80'(exp_q.size()), 80'd0);
        chk("rnd_drained", 80'(bus.out_valid), 80'd0);

        // Reset mid-frame with one full frame pending
        for (int r = 0; r < 13; r++) begin
            mk(128, r % 8, re, im);
            cyc(1'b1, re, im, 1'b0);
        end
        chk("pre_rst_valid", 80'(bus.out_valid), 80'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_in_ready", 80'(bus.in_ready), 80'd1);
        chk("mid_rst_out_valid", 80'(bus.out_valid), 80'd0);
        chk("mid_rst_doutre", bus.doutre, 80'd0);
        chk("mid_rst_out_col", 80'(bus.out_col), 80'd0);
        mrow = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Extremes in lanes 0 and 7 after the reset
        for (int r = 0; r < 8; r++) begin
            mk(0, r, re, im);
            re[9:0]   = ext[r % 3];
            re[79:70] = ext[(r + 1) % 3];
            im[9:0]   = ext[(r + 2) % 3];
            im[79:70] = ext[r % 3];
            cyc(1'b1, re, im, 1'b1);
        end
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, '0, '0, 1'b1);
            if (c == 0) begin
                chk("ext_c0_re_l0", 80'(bus.doutre[9:0]), 80'h1FF);
                chk("ext_c0_re_l1", 80'(bus.doutre[19:10]), 80'h200);
                chk("ext_c0_re_l2", 80'(bus.doutre[29:20]), 80'h000);
                chk("ext_c0_im_l0", 80'(bus.doutim[9:0]), 80'h000);
                chk("ext_c0_im_l1", 80'(bus.doutim[19:10]), 80'h1FF);
            end
            if (c == 7) begin
                chk("ext_c7_re_l0", 80'(bus.doutre[9:0]), 80'h200);
                chk("ext_c7_re_l7", 80'(bus.doutre[79:70]), 80'h000);
                chk("ext_c7_im_l6", 80'(bus.doutim[69:60]), 80'h1FF);
                chk("ext_c7_im_l7", 80'(bus.doutim[79:70]), 80'h200);
            end
        end
        cyc(1'b0, '0, '0, 1'b1);
        chk("ext_no_stale", 80'(bus.out_valid), 80'd0);
        chk("ext_q_empty", 80'(exp_q.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
